usb_buffer_arbiter: RTL

- Owns access sequencing for the 1 KiB USB data buffer (256 x 32-bit words, byte-write-enabled, 1-cycle read latency).
- The buffer is shared between the core data port and the USB engine.
- Tracks buffer ownership (the usb_packet_ready handoff) with a small FSM and grants the single RAM port only to the current owner.
- Inserts a dead cycle on every ownership change so an in-flight read always returns to the requester that issued it; counts access violations.

---
 rtl/usb_buffer_arbiter_pkg.sv | 32 +++
 rtl/usb_buffer_arbiter_if.sv | 38 +++
 rtl/usb_buffer_ownership_fsm.sv | 42 ++++
 rtl/usb_buffer_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/usb_buffer_arbiter_pkg.sv
// Shared constants and types for the USB data buffer arbiter.
package usb_buffer_arbiter_pkg;

    // Core-side memory map of the USB peripheral.
    localparam logic [31:0] USB_CONTROL_REG_ADDR  = 32'h0000_1000;
    localparam logic [31:0] USB_DATA_BUFFER_BASE  = 32'h0000_2000;
    localparam int          USB_DATA_BUFFER_SIZE  = 1024;

    // The buffer is organised as 32-bit words.
    localparam int USB_BUFFER_WORDS         = USB_DATA_BUFFER_SIZE / 4;
    localparam int USB_BUFFER_ADDRESS_WIDTH = $clog2(USB_BUFFER_WORDS);

    // Buffer ownership; the TO_* states are the dead cycles between owners.
    typedef enum logic [1:0] {
        USB_OWNS  = 2'd0,
        TO_CORE   = 2'd1,
        CORE_OWNS = 2'd2,
        TO_USB    = 2'd3
    } own_state_t;

    // Which requester a pending read belongs to.
    typedef enum logic {
        SIDE_CORE = 1'b0,
        SIDE_USB  = 1'b1
    } side_t;

    // usb_packet_ready is high once the handoff to the core has begun.
    function automatic logic is_core_phase(input own_state_t s);
        return (s == TO_CORE) || (s == CORE_OWNS);
    endfunction

endpackage

// File: rtl/usb_buffer_arbiter_if.sv
// Request/response bundle for the two buffer requesters (core and USB engine).
interface usb_buffer_arbiter_if
    import usb_buffer_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = USB_BUFFER_ADDRESS_WIDTH
);
    logic                     core_valid;
    logic [ADDRESS_WIDTH-1:0] core_address;
    logic [3:0]               core_write_sections;
    logic [31:0]              core_write_value;
    logic                     core_ready;
    logic [31:0]              core_read_value;
    logic                     core_read_valid;

    logic                     usb_valid;
    logic [ADDRESS_WIDTH-1:0] usb_address;
    logic [3:0]               usb_write_sections;
    logic [31:0]              usb_write_value;
    logic                     usb_ready;
    logic [31:0]              usb_read_value;
    logic                     usb_read_valid;

    // Requesters side.
    modport master (
        output core_valid, core_address, core_write_sections, core_write_value,
        input  core_ready, core_read_value, core_read_valid,
        output usb_valid, usb_address, usb_write_sections, usb_write_value,
        input  usb_ready, usb_read_value, usb_read_valid
    );

    // Arbiter side.
    modport slave (
        input  core_valid, core_address, core_write_sections, core_write_value,
        output core_ready, core_read_value, core_read_valid,
        input  usb_valid, usb_address, usb_write_sections, usb_write_value,
        output usb_ready, usb_read_value, usb_read_valid
    );
endinterface

// File: rtl/usb_buffer_ownership_fsm.sv
// Buffer ownership state machine: USB -> core on got_usb_packet, core -> USB
// on release_buffer, with a one-cycle dead state on each change.
module usb_buffer_ownership_fsm
    import usb_buffer_arbiter_pkg::*;
(
    input  logic       clk48,
    input  logic       reset,
    input  logic       got_usb_packet,
    input  logic       release_buffer,
    output own_state_t state,
    output logic       usb_packet_ready
);
    own_state_t r_state;
    own_state_t w_state_next;
    logic       r_usb_packet_ready;

    // Next-state logic; got_usb_packet has priority over release_buffer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            USB_OWNS:  if (got_usb_packet) w_state_next = TO_CORE;
            TO_CORE:   w_state_next = CORE_OWNS;
            CORE_OWNS: if (release_buffer && !got_usb_packet) w_state_next = TO_USB;
            TO_USB:    w_state_next = USB_OWNS;
            default:   w_state_next = USB_OWNS;
        endcase
    end

    // State register and registered ownership flag.
    always_ff @(posedge clk48) begin
        if (reset) begin
            r_state            <= USB_OWNS;
            r_usb_packet_ready <= 1'b0;
        end else begin
            r_state            <= w_state_next;
            r_usb_packet_ready <= is_core_phase(w_state_next);
        end
    end

    assign state            = r_state;
    assign usb_packet_ready = r_usb_packet_ready;
endmodule

// File: rtl/usb_buffer_arbiter.sv
// Grants the single buffer RAM port to the current owner, routes read data
// back to the requester that issued the read, and counts non-owner writes.
module usb_buffer_arbiter
    import usb_buffer_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH         = USB_BUFFER_ADDRESS_WIDTH,
    parameter int VIOLATION_COUNT_WIDTH = 8
)(
    input  logic                             clk48,
    input  logic                             reset,
    usb_buffer_arbiter_if.slave              bus,
    input  logic                             got_usb_packet,
    input  logic                             release_buffer,
    output logic                             usb_packet_ready,
    output logic [ADDRESS_WIDTH-1:0]         ram_address,
    output logic [3:0]                       ram_write_sections,
    output logic [31:0]                      ram_write_value,
    input  logic [31:0]                      ram_read_value,
    output logic [VIOLATION_COUNT_WIDTH-1:0] violation_count
);
    own_state_t                       w_state;
    logic                             w_core_grant;
    logic                             w_usb_grant;
    logic                             w_core_read;
    logic                             w_usb_read;
    logic                             w_core_violation;
    logic                             w_usb_violation;
    logic [VIOLATION_COUNT_WIDTH:0]   w_violation_sum;
    logic [VIOLATION_COUNT_WIDTH-1:0] w_violation_next;
    logic                             w_core_read_valid;
    logic                             w_usb_read_valid;
    logic [31:0]                      w_core_read_value;
    logic [31:0]                      w_usb_read_value;

    logic [ADDRESS_WIDTH-1:0]         r_last_address;
    logic                             r_pending_valid;
    side_t                            r_pending_side;
    logic [31:0]                      r_core_read_hold;
    logic [31:0]                      r_usb_read_hold;
    logic [VIOLATION_COUNT_WIDTH-1:0] r_violation_count;

    usb_buffer_ownership_fsm u_fsm (
        .clk48            (clk48),
        .reset            (reset),
        .got_usb_packet   (got_usb_packet),
        .release_buffer   (release_buffer),
        .state            (w_state),
        .usb_packet_ready (usb_packet_ready)
    );

    // Only the owner in a settled state is granted; transition states grant nobody.
    assign w_core_grant = bus.core_valid && (w_state == CORE_OWNS);
    assign w_usb_grant  = bus.usb_valid  && (w_state == USB_OWNS);
    assign w_core_read  = w_core_grant && (bus.core_write_sections == 4'b0000);
    assign w_usb_read   = w_usb_grant  && (bus.usb_write_sections  == 4'b0000);

    assign w_core_violation = bus.core_valid && (bus.core_write_sections != 4'b0000) && !w_core_grant;
    assign w_usb_violation  = bus.usb_valid  && (bus.usb_write_sections  != 4'b0000) && !w_usb_grant;

    // RAM port mux; the address parks on its last value when idle.
    always_comb begin
        ram_address        = r_last_address;
        ram_write_sections = 4'b0000;
        ram_write_value    = 32'h0000_0000;
        if (w_core_grant) begin
            ram_address        = bus.core_address;
            ram_write_sections = bus.core_write_sections;
            ram_write_value    = bus.core_write_value;
        end else if (w_usb_grant) begin
            ram_address        = bus.usb_address;
            ram_write_sections = bus.usb_write_sections;
            ram_write_value    = bus.usb_write_value;
        end
    end

    // Read data is steered by the tag captured when the read was granted.
    assign w_core_read_valid = r_pending_valid && (r_pending_side == SIDE_CORE);
    assign w_usb_read_valid  = r_pending_valid && (r_pending_side == SIDE_USB);
    assign w_core_read_value = w_core_read_valid ? ram_read_value : r_core_read_hold;
    assign w_usb_read_value  = w_usb_read_valid  ? ram_read_value : r_usb_read_hold;

    // Both sides can violate in the same cycle, so add up to two and saturate.
    assign w_violation_sum  = {1'b0, r_violation_count}
                            + (VIOLATION_COUNT_WIDTH+1)'(w_core_violation)
                            + (VIOLATION_COUNT_WIDTH+1)'(w_usb_violation);
    assign w_violation_next = w_violation_sum[VIOLATION_COUNT_WIDTH]
                            ? {VIOLATION_COUNT_WIDTH{1'b1}}
                            : w_violation_sum[VIOLATION_COUNT_WIDTH-1:0];

    // Address park, pending-read tag, read-data holds and violation counter.
    always_ff @(posedge clk48) begin
        if (reset) begin
            r_last_address    <= '0;
            r_pending_valid   <= 1'b0;
            r_pending_side    <= SIDE_CORE;
            r_core_read_hold  <= 32'h0000_0000;
            r_usb_read_hold   <= 32'h0000_0000;
            r_violation_count <= '0;
        end else begin
            r_last_address    <= ram_address;
            r_pending_valid   <= w_core_read || w_usb_read;
            r_pending_side    <= w_usb_read ? SIDE_USB : SIDE_CORE;
            r_core_read_hold  <= w_core_read_value;
            r_usb_read_hold   <= w_usb_read_value;
            r_violation_count <= w_violation_next;
        end
    end

    assign bus.core_ready      = w_core_grant;
    assign bus.usb_ready       = w_usb_grant;
    assign bus.core_read_valid = w_core_read_valid;
    assign bus.usb_read_valid  = w_usb_read_valid;
    assign bus.core_read_value = w_core_read_value;
    assign bus.usb_read_value  = w_usb_read_value;
    assign violation_count     = r_violation_count;
endmodule
